// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: sequences branch redirects, flush windows and decode stalls.
// Interrupt entry/return is compiled in only when FETCH_CTRL_IRQ_EN is defined.
module fetch_ctrl #(
   parameter int unsigned          PC_WIDTH     = 16,
   parameter logic [PC_WIDTH-1:0]  PC_INITIAL   = '0,
   parameter int unsigned          FLUSH_CYCLES = 2,
   parameter logic [PC_WIDTH-1:0]  IRQ_VECTOR   = PC_WIDTH'(4)
) (
   input  logic                clk_in,
   input  logic                RST,
   input  logic                fetch_done,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   input  logic                br_req,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                stall_req,
   input  logic                irq_req,
   input  logic                irq_ret,
   output logic                pc_chg,
   output logic [PC_WIDTH-1:0] pc_in,
   output logic                flush,
   output logic                irq_ack,
   output logic [PC_WIDTH-1:0] epc
);

   typedef enum logic [1:0] {StIdle, StRun, StStall, StFlush} state_e;

   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

   state_e              state_q;
   logic                pc_chg_q;
   logic [PC_WIDTH-1:0] pc_in_q;
   logic                flush_q;
   logic [PC_WIDTH-1:0] hold_q;
   logic [3:0]          cnt_q;

   logic                redir;
   logic [PC_WIDTH-1:0] redir_pc;

`ifdef FETCH_CTRL_IRQ_EN
   logic                irq_en_q;
   logic                irq_ack_q;
   logic [PC_WIDTH-1:0] epc_q;
   logic                take_irq;
   logic                take_ret;
`else
   logic                unused_irq;
   assign unused_irq = irq_req ^ irq_ret;
`endif

   // Redirect source selection: branch beats return beats interrupt entry.
   always_comb begin
      redir    = br_req;
      redir_pc = br_target;
`ifdef FETCH_CTRL_IRQ_EN
      take_irq = 1'b0;
      take_ret = 1'b0;
      if (!br_req) begin
         if (irq_ret && !irq_en_q) begin
            redir    = 1'b1;
            take_ret = 1'b1;
            redir_pc = epc_q;
         end else if (irq_req && irq_en_q) begin
            redir    = 1'b1;
            take_irq = 1'b1;
            redir_pc = IRQ_VECTOR;
         end
      end
`endif
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         state_q  <= StIdle;
         pc_chg_q <= 1'b0;
         pc_in_q  <= PC_INITIAL;
         flush_q  <= 1'b0;
         hold_q   <= PC_INITIAL;
         cnt_q    <= '0;
`ifdef FETCH_CTRL_IRQ_EN
         irq_en_q  <= 1'b1;
         irq_ack_q <= 1'b0;
         epc_q     <= '0;
`endif
      end else begin
`ifdef FETCH_CTRL_IRQ_EN
         irq_ack_q <= 1'b0;
`endif
         if (state_q == StIdle) begin
            pc_chg_q <= 1'b0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
            if (fetch_done) begin
               state_q <= StRun;
            end
         end else if (!fetch_done) begin
            state_q  <= StIdle;
            pc_chg_q <= 1'b0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
         end else if (redir) begin
            state_q  <= StFlush;
            pc_chg_q <= 1'b1;
            pc_in_q  <= redir_pc;
            flush_q  <= 1'b1;
            cnt_q    <= FlushLoad;
`ifdef FETCH_CTRL_IRQ_EN
            if (take_ret) begin
               irq_en_q <= 1'b1;
            end
            if (take_irq) begin
               irq_en_q  <= 1'b0;
               irq_ack_q <= 1'b1;
               epc_q     <= fetch_pc;
            end
`endif
         end else begin
            unique case (state_q)
               StFlush: begin
                  pc_chg_q <= 1'b0;
                  if (cnt_q > 4'd1) begin
                     cnt_q   <= cnt_q - 4'd1;
                     flush_q <= 1'b1;
                  end else begin
                     // Last wrong-path slot: leave flush, honouring a pending stall.
                     cnt_q   <= '0;
                     flush_q <= 1'b0;
                     if (stall_req) begin
                        state_q  <= StStall;
                        hold_q   <= fetch_pc;
                        pc_chg_q <= 1'b1;
                        pc_in_q  <= fetch_pc;
                     end else begin
                        state_q <= StRun;
                     end
                  end
               end
               StStall: begin
                  flush_q <= 1'b0;
                  if (stall_req) begin
                     pc_chg_q <= 1'b1;
                     pc_in_q  <= hold_q;
                  end else begin
                     state_q  <= StRun;
                     pc_chg_q <= 1'b0;
                  end
               end
               default: begin
                  flush_q <= 1'b0;
                  if (stall_req) begin
                     state_q  <= StStall;
                     hold_q   <= fetch_pc;
                     pc_chg_q <= 1'b1;
                     pc_in_q  <= fetch_pc;
                  end else begin
                     pc_chg_q <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign pc_chg = pc_chg_q;
   assign pc_in  = pc_in_q;
   assign flush  = flush_q;
`ifdef FETCH_CTRL_IRQ_EN
   assign irq_ack = irq_ack_q;
   assign epc     = epc_q;
`else
   assign irq_ack = 1'b0;
   assign epc     = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked against a
// cycle-level behavioural model. Interrupt scenarios follow FETCH_CTRL_IRQ_EN.
module tb_fetch_ctrl;

   localparam int unsigned W   = 16;
   localparam int unsigned FC  = 2;
   localparam logic [15:0] VEC = 16'h0004;
`ifdef FETCH_CTRL_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   logic          clk_in = 1'b0;
   logic          RST = 1'b0;
   logic          fetch_done = 1'b0;
   logic [W-1:0]  fetch_pc = '0;
   logic          br_req = 1'b0;
   logic [W-1:0]  br_target = '0;
   logic          stall_req = 1'b0;
   logic          irq_req = 1'b0;
   logic          irq_ret = 1'b0;
   logic          pc_chg;
   logic [W-1:0]  pc_in;
   logic          flush;
   logic          irq_ack;
   logic [W-1:0]  epc;

   fetch_ctrl #(
      .PC_WIDTH     (W),
      .PC_INITIAL   (16'h0000),
      .FLUSH_CYCLES (FC),
      .IRQ_VECTOR   (VEC)
   ) dut (
      .clk_in     (clk_in),
      .RST        (RST),
      .fetch_done (fetch_done),
      .fetch_pc   (fetch_pc),
      .br_req     (br_req),
      .br_target  (br_target),
      .stall_req  (stall_req),
      .irq_req    (irq_req),
      .irq_ret    (irq_ret),
      .pc_chg     (pc_chg),
      .pc_in      (pc_in),
      .flush      (flush),
      .irq_ack    (irq_ack),
      .epc        (epc)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // Behavioural model: active flag, remaining flush slots, stall flag.
   bit          m_active;
   int          m_flush_left;
   bit          m_stalled;
   bit          m_ien;
   logic [15:0] m_hold, m_pc_in, m_epc;
   logic        m_chg, m_fl, m_ack;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("pc_chg", 16'(pc_chg), 16'(m_chg));
      check("pc_in", pc_in, m_pc_in);
      check("flush", 16'(flush), 16'(m_fl));
      check("irq_ack", 16'(irq_ack), 16'(m_ack));
      check("epc", epc, m_epc);
   endtask

   task automatic model_reset();
      m_active = 0; m_flush_left = 0; m_stalled = 0; m_ien = 1;
      m_hold = 16'h0000; m_pc_in = 16'h0000; m_epc = 16'h0000;
      m_chg = 0; m_fl = 0; m_ack = 0;
   endtask

   task automatic model_redirect(input logic [15:0] t);
      m_flush_left = FC; m_stalled = 0;
      m_chg = 1; m_fl = 1; m_pc_in = t;
   endtask

   task automatic model_step();
      m_ack = 0;
      if (!m_active) begin
         m_chg = 0; m_fl = 0;
         if (fetch_done) m_active = 1;
      end else if (!fetch_done) begin
         m_active = 0; m_chg = 0; m_fl = 0; m_flush_left = 0; m_stalled = 0;
      end else if (br_req) begin
         model_redirect(br_target);
      end else if (IrqEn && irq_ret && !m_ien) begin
         model_redirect(m_epc);
         m_ien = 1;
      end else if (IrqEn && irq_req && m_ien) begin
         m_epc = fetch_pc;
         model_redirect(VEC);
         m_ack = 1; m_ien = 0;
      end else if (m_flush_left > 1) begin
         m_flush_left--; m_chg = 0; m_fl = 1;
      end else if (m_flush_left == 1) begin
         m_flush_left = 0; m_fl = 0;
         if (stall_req) begin
            m_stalled = 1; m_hold = fetch_pc; m_chg = 1; m_pc_in = fetch_pc;
         end else begin
            m_chg = 0;
         end
      end else if (stall_req) begin
         if (!m_stalled) m_hold = fetch_pc;
         m_stalled = 1; m_chg = 1; m_pc_in = m_hold; m_fl = 0;
      end else begin
         m_stalled = 0; m_chg = 0; m_fl = 0;
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      model_step();
      #1;
      check_all();
   endtask

   // Asynchronous reset mid-cycle, held across one edge, released at posedge+1.
   task automatic pulse_reset();
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk_in);
      #1;
      check_all();
      RST = 1'b1;
   endtask

   initial begin
      model_reset();
      #1;
      check_all();
      @(posedge clk_in);
      #1;
      RST = 1'b1;
      fetch_done = 1'b1;
      step();
      check("run_pc_in", pc_in, 16'h0000);

      // Branch redirect and flush window.
      br_req = 1'b1; br_target = 16'h0040;
      step();
      check("br_chg", 16'(pc_chg), 16'h0001);
      check("br_pc", pc_in, 16'h0040);
      br_req = 1'b0;
      step();
      check("flush2", 16'(flush), 16'h0001);
      step();
      check("flush_end", 16'(flush), 16'h0000);
      step();

      // Three-cycle stall.
      stall_req = 1'b1; fetch_pc = 16'h0012;
      repeat (3) begin
         step();
         check("stall_pc", pc_in, 16'h0012);
      end
      stall_req = 1'b0;
      step();
      check("stall_rel", 16'(pc_chg), 16'h0000);

      // Branch beats stall; stall taken only when the flush ends.
      stall_req = 1'b1; br_req = 1'b1; br_target = 16'h0080; fetch_pc = 16'h0033;
      step();
      check("br_wins", pc_in, 16'h0080);
      br_req = 1'b0;
      step();
      step();
      stall_req = 1'b0;
      step();

      // Interrupt entry, ignored second request, return.
      fetch_pc = 16'h0020; irq_req = 1'b1;
      step();
      step();
      step();
      irq_req = 1'b0;
      step();
      irq_ret = 1'b1;
      step();
      irq_ret = 1'b0;
      repeat (3) step();

      // Reset in the middle of a flush, then wait in IDLE for fetch_done.
      br_req = 1'b1; br_target = 16'h0100;
      step();
      br_req = 1'b0;
      fetch_done = 1'b0;
      pulse_reset();
      br_req = 1'b1; stall_req = 1'b1;
      repeat (3) step();
      br_req = 1'b0; stall_req = 1'b0;
      fetch_done = 1'b1;
      step();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         fetch_done = ($urandom_range(99) >= 4);
         fetch_pc   = 16'($urandom);
         br_req     = ($urandom_range(99) < 10);
         br_target  = 16'($urandom);
         stall_req  = ($urandom_range(99) < 30);
         irq_req    = ($urandom_range(99) < 12);
         irq_ret    = ($urandom_range(99) < 10);
         if ($urandom_range(99) == 0) begin
            pulse_reset();
         end else begin
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
